riscv_ahb_sram_slave: RTL
=========================

Name: riscv_ahb_sram_slave

Overview:
AHB (AMBA 2.0) slave that responds to transfers from the PicoRV AHB master through the GRLIB bus, fronting an on-chip SRAM for instruction and data storage. Supports single transfers of byte, halfword and word, with a configurable number of wait states. Gives a two-cycle ERROR response for out-of-range, oversized or misaligned accesses. Byte lanes are little-endian to match PicoRV32.

Parameters:
ADDR_WDT, 10, word-address bits; SRAM depth = 2^ADDR_WDT words (default 4 KiB)
BASE_ADDR, 32'h4000_0000, byte base address of the SRAM window; must be aligned to 4*2^ADDR_WDT
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15)

Ports:
HCLK  in  1  bus clock, all logic rising-edge
HRESETn  in  1  reset, asynchronous, active-low
HSELx  in  1  slave select from the GRLIB decoder
HADDR  in  32  address-phase byte address
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWRITE  in  1  1 = write
HSIZE  in  3  0 = byte, 1 = half, 2 = word; >2 gives ERROR
HBURST  in  3  ignored; every beat is treated as an independent transfer
HPROT  in  4  ignored
HWDATA  in  32  data-phase write data
HREADY  in  1  bus-level ready (previous transfer completing)
HREADYOUT  out  1  slave ready
HRESP  out  2  OKAY=0, ERROR=1; RETRY and SPLIT never issued
HRDATA  out  32  read data
HSPLITx  out  16  tied to 0

Behaviour:
- Accept condition, evaluated each cycle: HSELx & HREADY & HTRANS[1]. On accept, register the following:
  - address, write flag, size
  - error flag: address outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_WDT), or HSIZE>2, or (HSIZE=1 & HADDR[0]), or (HSIZE=2 & HADDR[1:0]!=0)
- IDLE or BUSY selected, or HSELx=0: no data phase. Response is HREADYOUT=1, HRESP=OKAY.
- FSM states:
  - S_IDLE: HREADYOUT=1, HRESP=OKAY. On accept with error → S_ERR1. On accept, no error, WAIT_STATES>0 → S_WAIT, load cnt=WAIT_STATES-1. On accept, no error, WAIT_STATES=0 → stay in S_IDLE, with the data phase completing next cycle.
  - S_WAIT: HREADYOUT=0, HRESP=OKAY. cnt decrements; at cnt=0 → S_DONE.
  - S_DONE: HREADYOUT=1, HRESP=OKAY; the data phase completes. May accept a new transfer with the same transitions as S_IDLE; otherwise → S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=ERROR → S_ERR2.
  - S_ERR2: HREADYOUT=1, HRESP=ERROR. May accept a new transfer, same transitions as S_IDLE; otherwise → S_IDLE.
- Zero-wait latency: address phase in cycle N; data phase in N+1 with HREADYOUT=1. Each wait state adds one cycle.
- Reads:
  - The SRAM read is launched at the accept edge, or on the last wait cycle, so HRDATA is valid in the completing data-phase cycle.
  - All 4 lanes are driven with the full word; the master selects the lane.
  - HRDATA holds its last value outside read data phases.
- Writes:
  - Committed at the edge ending the completing data phase (HREADYOUT=1), using HWDATA sampled in that cycle.
  - Byte enables: size 0 → lane addr[1:0]; size 1 → lanes {addr[1],0} and {addr[1],1}; size 2 → all lanes. Lane k = HWDATA[8k+7:8k].
  - Errored transfers never write SRAM and never update HRDATA.
- Read-after-write hazard: a read address phase accepted in the same cycle as a completing write data phase to the same word returns the merged word (written bytes forwarded, other bytes from SRAM).
- Reset (HRESETn=0, asynchronous):
  - FSM → S_IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, cnt=0, registered address-phase valid=0.
  - SRAM contents are not reset.
  - Reset asserted mid-transfer aborts it; no write is committed.
- HREADY low with HSELx high: nothing is sampled (another slave is stalling).

Decomposition:
- Shared package riscv_ahb_pkg:
  - HTRANS_{IDLE,BUSY,NONSEQ,SEQ}
  - HRESP_{OKAY,ERROR,RETRY,SPLIT}
  - HSIZE_{BYTE,HALF,WORD}
  - the slave FSM state encoding
  - a byte-enable function of (size, addr[1:0])
- One sub-module, riscv_ahb_ram_1r1w: 2^ADDR_WDT x 32 SRAM with one synchronous read port, one write port and 4-bit byte write enable. It is inferable as block RAM; read-during-write returns old data, and forwarding is handled in the parent.

Test Plan:
1. After reset, WAIT_STATES=0: word write 0xDEADBEEF @BASE+0x10, then word read @0x10 → HRDATA=0xDEADBEEF in the cycle after the read address phase, HREADYOUT=1 throughout, HRESP=OKAY.
2. Byte write 0xAA @+0x11, then half write 0x5566 @+0x12 over word 0x00000000 → word read returns 0x5566AA00.
3. Back-to-back write @+0x20 (0x11223344) then read @+0x20 in the next address phase → read returns 0x11223344 (forwarding path).
4. Word read @BASE+4*2^ADDR_WDT, and half read @+0x1 → each gives HREADYOUT 0 then 1 with HRESP=ERROR in both cycles; SRAM is unchanged.
5. WAIT_STATES=3: word read → HREADYOUT low exactly 3 cycles, then high with valid data; an HTRANS=BUSY or IDLE beat gives no stall.
6. HRESETn asserted during S_WAIT of a write → outputs immediately return to reset values; a subsequent read shows the old contents.

Source files
------------

// File: rtl/riscv_ahb_pkg.sv
// Shared AHB encodings, slave FSM state codes and byte-lane helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package riscv_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [1:0] HRESP_OKAY  = 2'd0;
   localparam logic [1:0] HRESP_ERROR = 2'd1;
   localparam logic [1:0] HRESP_RETRY = 2'd2;
   localparam logic [1:0] HRESP_SPLIT = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // Slave FSM encoding
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_DONE = 3'd2;
   localparam logic [2:0] S_ERR1 = 3'd3;
   localparam logic [2:0] S_ERR2 = 3'd4;

   // Little-endian byte lanes touched by a transfer of the given size
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
      case (size)
         HSIZE_BYTE: byte_en = 4'b0001 << lane;
         HSIZE_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
         default:    byte_en = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/riscv_ahb_ram_1r1w.sv
// 2^ADDR_WDT x 32 SRAM, one synchronous read port, one byte-masked write port.
// Latency: read data one cycle after rd_en; read-during-write returns old data.
// Backpressure: none, accepts a read and a write every cycle.
// Ports: core_clk; rd_en/rd_addr -> rd_dat; wr_en/wr_be/wr_addr/wr_dat.
module riscv_ahb_ram_1r1w #(
   parameter int ADDR_WDT = 10
) (
   input  logic                core_clk,
   input  logic                rd_en,
   input  logic [ADDR_WDT-1:0] rd_addr,
   output logic [31:0]         rd_dat,
   input  logic                wr_en,
   input  logic [3:0]          wr_be,
   input  logic [ADDR_WDT-1:0] wr_addr,
   input  logic [31:0]         wr_dat
);

   logic [31:0] mem [2**ADDR_WDT];

   // No reset on the array or read register so the tools map this onto block RAM
   always_ff @(posedge core_clk) begin
      if (rd_en)
         rd_dat <= mem[rd_addr];
      if (wr_en) begin
         for (int k = 0; k < 4; k++)
            if (wr_be[k])
               mem[wr_addr][8*k +: 8] <= wr_dat[8*k +: 8];
      end
   end

endmodule

// File: rtl/riscv_ahb_sram_slave.sv
// AHB slave fronting an on-chip SRAM: byte/half/word singles, two-cycle ERROR response.
// Latency: data phase completes 1 + WAIT_STATES cycles after the address phase.
// Backpressure: HREADYOUT low during wait states and the first ERROR cycle.
// Ports: HCLK/HRESETn; AHB address phase (HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
//        HPROT, HREADY), HWDATA; responses HREADYOUT, HRESP, HRDATA, HSPLITx.
module riscv_ahb_sram_slave
   import riscv_ahb_pkg::*;
#(
   parameter int          ADDR_WDT    = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSELx,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA,
   output logic [15:0] HSPLITx
);

   logic [2:0]          state;
   logic [3:0]          cnt;
   logic                dp_vld;     // non-errored data phase outstanding
   logic                dp_write;
   logic [ADDR_WDT+1:0] dp_addr;
   logic [2:0]          dp_size;
   logic [3:0]          fwd_be;     // lanes of HRDATA taken from fwd_dat instead of SRAM
   logic [31:0]         fwd_dat;
   logic                rd_seen;    // holds HRDATA at zero until the first read after reset
   logic [31:0]         ram_rd;

   logic ready_int, accept, in_range, misalign, addr_err, complete;
   logic wr_en, rd_en, rd_fwd;
   logic [3:0] wr_be;
   logic unused_ok;

   assign ready_int = (state != S_WAIT) && (state != S_ERR1);
   // Gating with ready_int keeps a misbehaving HREADY from restarting us mid data phase
   assign accept    = HSELx & HREADY & HTRANS[1] & ready_int;

   // Window is aligned to its size, so only the upper bits need to match
   assign in_range = (HADDR[31:ADDR_WDT+2] == BASE_ADDR[31:ADDR_WDT+2]);
   assign misalign = ((HSIZE == HSIZE_HALF) & HADDR[0]) |
                     ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));
   assign addr_err = ~in_range | (HSIZE > HSIZE_WORD) | misalign;

   // A pending data phase completes whenever we drive HREADYOUT high
   assign complete = dp_vld & ((state == S_IDLE) | (state == S_DONE));
   assign wr_en    = complete & dp_write;
   assign wr_be    = byte_en(dp_size, dp_addr[1:0]);
   assign rd_en    = accept & ~addr_err & ~HWRITE;
   // Read launched on the same edge a write to that word commits sees stale SRAM data
   assign rd_fwd   = wr_en & (dp_addr[ADDR_WDT+1:2] == HADDR[ADDR_WDT+1:2]);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         dp_vld   <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         dp_size  <= '0;
         fwd_be   <= '0;
         fwd_dat  <= '0;
         rd_seen  <= 1'b0;
      end else begin
         if (accept) begin
            dp_vld   <= ~addr_err;
            dp_write <= HWRITE;
            dp_addr  <= HADDR[ADDR_WDT+1:0];
            dp_size  <= HSIZE;
         end else if (complete) begin
            dp_vld <= 1'b0;
         end

         if (rd_en) begin
            rd_seen <= 1'b1;
            fwd_be  <= rd_fwd ? wr_be : 4'b0000;
            fwd_dat <= HWDATA;
         end

         case (state)
            S_WAIT: begin
               if (cnt == 4'd0)
                  state <= S_DONE;
               else
                  cnt <= cnt - 4'd1;
            end
            S_ERR1: state <= S_ERR2;
            default: begin
               // S_IDLE, S_DONE and S_ERR2 all accept the next address phase
               if (accept && addr_err) begin
                  state <= S_ERR1;
               end else if (accept && (WAIT_STATES > 0)) begin
                  state <= S_WAIT;
                  cnt   <= 4'(WAIT_STATES - 1);
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   riscv_ahb_ram_1r1w #(
      .ADDR_WDT (ADDR_WDT)
   ) u_ram (
      .core_clk (HCLK),
      .rd_en    (rd_en),
      .rd_addr  (HADDR[ADDR_WDT+1:2]),
      .rd_dat   (ram_rd),
      .wr_en    (wr_en),
      .wr_be    (wr_be),
      .wr_addr  (dp_addr[ADDR_WDT+1:2]),
      .wr_dat   (HWDATA)
   );

   // RAM output register only moves on a launch, so HRDATA holds between reads
   always_comb begin
      HRDATA = '0;
      if (rd_seen)
         for (int k = 0; k < 4; k++)
            HRDATA[8*k +: 8] = fwd_be[k] ? fwd_dat[8*k +: 8] : ram_rd[8*k +: 8];
   end

   assign HREADYOUT = ready_int;
   assign HRESP     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign HSPLITx   = '0;

   assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

endmodule
